prime_search_ctrl: RTL and testbench

Sequencing controller that drives a shared multi-cycle Miller-Rabin round engine to search an inclusive integer range for primes. It walks candidates upward from a programmed start value, filters trivial cases in-house, issues one engine round per witness base, and streams each accepted prime out over a valid/ready handshake. It sits between the host/configuration logic and the primality datapath; the engine itself is external.

---
 rtl/prime_search_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_prime_search_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_search_ctrl.sv
// Sequencing controller that walks a candidate range and drives an external
// Miller-Rabin round engine, streaming accepted primes over valid/ready.
module prime_search_ctrl #(
  parameter int WIDTH       = 64,
  parameter int NUM_WITNESS = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_start_value,
  input  logic [WIDTH-1:0] i_limit,
  input  logic             i_abort,
  output logic             o_eng_req,
  output logic [WIDTH-1:0] o_eng_n,
  output logic [WIDTH-1:0] o_eng_a,
  input  logic             i_eng_gnt,
  input  logic             i_eng_done,
  input  logic             i_eng_composite,
  output logic             o_prime_valid,
  input  logic             i_prime_ready,
  output logic [WIDTH-1:0] o_prime_data,
  output logic             o_busy,
  output logic             o_done,
  output logic [31:0]      o_prime_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILTER = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_EMIT   = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;
  localparam logic [2:0] S_DRAIN  = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam logic [3:0]       W_LAST   = 4'(NUM_WITNESS - 1);
  localparam logic [WIDTH-1:0] CAND_TWO = WIDTH'(2);
  localparam logic [WIDTH-1:0] CAND_MAX = {WIDTH{1'b1}};
  localparam logic [31:0]      CNT_MAX  = 32'hFFFF_FFFF;

  function automatic logic [5:0] witness_base(input logic [3:0] idx);
    case (idx)
      4'd0:    witness_base = 6'd2;
      4'd1:    witness_base = 6'd3;
      4'd2:    witness_base = 6'd5;
      4'd3:    witness_base = 6'd7;
      4'd4:    witness_base = 6'd11;
      4'd5:    witness_base = 6'd13;
      4'd6:    witness_base = 6'd17;
      4'd7:    witness_base = 6'd19;
      4'd8:    witness_base = 6'd23;
      4'd9:    witness_base = 6'd29;
      4'd10:   witness_base = 6'd31;
      default: witness_base = 6'd37;
    endcase
  endfunction

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_lim;
  logic [3:0]       r_w;
  logic             r_eng_req;
  logic [WIDTH-1:0] r_eng_n;
  logic [WIDTH-1:0] r_eng_a;
  logic             r_prime_valid;
  logic [WIDTH-1:0] r_prime_data;
  logic             r_busy;
  logic             r_done;
  logic [31:0]      r_prime_count;

  logic [WIDTH-1:0] w_base;
  logic             w_skip;
  logic             w_last;

  // current witness base and whether it is too large to be meaningful
  always_comb begin
    w_base = {{(WIDTH-6){1'b0}}, witness_base(r_w)};
    w_skip = (w_base >= r_cand);
    w_last = (r_w == W_LAST);
  end

  // controller state machine; every output is a register updated here
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_cand        <= '0;
      r_lim         <= '0;
      r_w           <= 4'd0;
      r_eng_req     <= 1'b0;
      r_eng_n       <= '0;
      r_eng_a       <= '0;
      r_prime_valid <= 1'b0;
      r_prime_data  <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_prime_count <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start && !i_abort) begin
            r_cand        <= i_start_value;
            r_lim         <= i_limit;
            r_w           <= 4'd0;
            r_prime_count <= 32'd0;
            if (i_start_value > i_limit) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FILTER;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end
        end
        S_FILTER: begin
          if (i_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cand < CAND_TWO) begin
            r_state <= S_NEXT;
          end else if (r_cand == CAND_TWO) begin
            r_state       <= S_EMIT;
            r_prime_valid <= 1'b1;
            r_prime_data  <= r_cand;
          end else if (!r_cand[0]) begin
            r_state <= S_NEXT;
          end else begin
            r_w     <= 4'd0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // a grant in the abort cycle leaves a result in flight that must be drained
          if (r_eng_req && i_eng_gnt) begin
            r_eng_req <= 1'b0;
            r_state   <= i_abort ? S_DRAIN : S_WAIT;
          end else if (i_abort) begin
            r_eng_req <= 1'b0;
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
          end else if (!r_eng_req) begin
            if (w_skip) begin
              if (w_last) begin
                r_state       <= S_EMIT;
                r_prime_valid <= 1'b1;
                r_prime_data  <= r_cand;
              end else begin
                r_w <= r_w + 4'd1;
              end
            end else begin
              r_eng_req <= 1'b1;
              r_eng_n   <= r_cand;
              r_eng_a   <= w_base;
            end
          end
        end
        S_WAIT: begin
          if (i_eng_done) begin
            if (i_abort) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else if (i_eng_composite) begin
              r_state <= S_NEXT;
            end else if (w_last) begin
              r_state       <= S_EMIT;
              r_prime_valid <= 1'b1;
              r_prime_data  <= r_cand;
            end else begin
              r_w     <= r_w + 4'd1;
              r_state <= S_ISSUE;
            end
          end else if (i_abort) begin
            r_state <= S_DRAIN;
          end
        end
        S_EMIT: begin
          if (i_abort) begin
            r_prime_valid <= 1'b0;
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
          end else if (i_prime_ready) begin
            r_prime_valid <= 1'b0;
            r_state       <= S_NEXT;
            if (r_prime_count != CNT_MAX) begin
              r_prime_count <= r_prime_count + 32'd1;
            end
          end
        end
        S_NEXT: begin
          if (i_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if ((r_cand == r_lim) || (r_cand == CAND_MAX)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cand  <= r_cand + CAND_TWO - WIDTH'(1);
            r_state <= S_FILTER;
          end
        end
        S_DRAIN: begin
          if (i_eng_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_eng_req     <= 1'b0;
          r_prime_valid <= 1'b0;
          r_busy        <= 1'b0;
          r_done        <= 1'b0;
        end
      endcase
    end
  end

  assign o_eng_req     = r_eng_req;
  assign o_eng_n       = r_eng_n;
  assign o_eng_a       = r_eng_a;
  assign o_prime_valid = r_prime_valid;
  assign o_prime_data  = r_prime_data;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_prime_count = r_prime_count;

endmodule

// File: tb/tb_prime_search_ctrl.sv
// Randomized bench for prime_search_ctrl: trial-division reference model feeds a
// scoreboard queue; an exact-answer engine model answers the round requests.
module tb_prime_search_ctrl;

  localparam int W  = 16;
  localparam int NW = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] start_value;
  logic [W-1:0] limit;
  logic         abort;
  logic         eng_req;
  logic [W-1:0] eng_n;
  logic [W-1:0] eng_a;
  logic         eng_gnt;
  logic         eng_done;
  logic         eng_comp;
  logic         prime_valid;
  logic         prime_ready;
  logic [W-1:0] prime_data;
  logic         busy;
  logic         done;
  logic [31:0]  prime_count;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int req_n[$];
  int req_a[$];
  int ready_mode = 0;
  int fixed_lat  = -1;
  int gnt_pct    = 70;
  int n_lo       = 0;
  int eng_last_n = -1;
  int eng_last_i = 0;
  bit granted_flag = 1'b0;
  int wl[12] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37};

  always #5 clk = ~clk;

  prime_search_ctrl #(.WIDTH(W), .NUM_WITNESS(NW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_start_value(start_value),
    .i_limit(limit), .i_abort(abort), .o_eng_req(eng_req), .o_eng_n(eng_n),
    .o_eng_a(eng_a), .i_eng_gnt(eng_gnt), .i_eng_done(eng_done),
    .i_eng_composite(eng_comp), .o_prime_valid(prime_valid),
    .i_prime_ready(prime_ready), .o_prime_data(prime_data), .o_busy(busy),
    .o_done(done), .o_prime_count(prime_count)
  );

  function automatic bit is_prime(int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) begin
      if (n % d == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // engine model: exact primality answer after a random latency
  initial begin : engine
    bit pend;
    int lat;
    int pn;
    bit p_req, p_gnt, p_abort;
    logic [W-1:0] p_n, p_a;
    int idx;
    pend = 1'b0; lat = 0; pn = 0;
    p_req = 1'b0; p_gnt = 1'b0; p_abort = 1'b0; p_n = '0; p_a = '0;
    eng_gnt = 1'b0; eng_done = 1'b0; eng_comp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (p_req && !p_gnt && !p_abort) begin
          check("eng_req_hold", eng_req, 1);
          check("eng_n_hold", eng_n, p_n);
          check("eng_a_hold", eng_a, p_a);
        end
        if (eng_req && eng_gnt) begin
          check("eng_n_odd", eng_n[0], 1);
          check("eng_n_in_range", (int'(eng_n) >= n_lo), 1);
          check("eng_a_below_n", (eng_a < eng_n), 1);
          if (int'(eng_n) != eng_last_n) begin
            eng_last_n = int'(eng_n);
            eng_last_i = 0;
          end else begin
            eng_last_i++;
          end
          idx = (eng_last_i < 12) ? eng_last_i : 11;
          check("eng_a_order", eng_a, wl[idx]);
          check("eng_rounds_le_nw", (eng_last_i < NW), 1);
          req_n.push_back(int'(eng_n));
          req_a.push_back(int'(eng_a));
          pend = 1'b1;
          pn   = int'(eng_n);
          lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
          granted_flag = 1'b1;
        end
      end
      p_req = eng_req; p_gnt = eng_gnt; p_abort = abort; p_n = eng_n; p_a = eng_a;
      @(posedge clk);
      #1;
      eng_done = 1'b0;
      eng_comp = 1'b0;
      if (pend) begin
        if (lat == 0) begin
          eng_done = 1'b1;
          eng_comp = !is_prime(pn);
          pend     = 1'b0;
        end else begin
          lat--;
        end
      end
      eng_gnt = !pend && (int'($urandom_range(0, 99)) < gnt_pct);
    end
  end

  // consumer ready pattern
  initial begin : ready_drv
    prime_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       prime_ready = 1'b1;
        1:       prime_ready = 1'($urandom_range(0, 1));
        default: prime_ready = 1'b0;
      endcase
    end
  end

  // monitor: pops the scoreboard on each prime handshake
  initial begin : monitor
    bit pv, pr, pa;
    logic [W-1:0] pd;
    pv = 1'b0; pr = 1'b0; pa = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr && !pa) begin
          check("prime_hold_valid", prime_valid, 1);
          check("prime_hold_data", prime_data, pd);
        end
        if (prime_valid && prime_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_prime: got %0d expected none", prime_data);
          end else begin
            check("prime_data", prime_data, exp_q.pop_front());
          end
        end
        pv = prime_valid; pr = prime_ready; pa = abort; pd = prime_data;
      end
    end
  end

  task automatic begin_search(int s, int l, output int ecount);
    exp_q.delete();
    req_n.delete();
    req_a.delete();
    eng_last_n = -1;
    n_lo = s;
    for (int n = s; n <= l; n++) begin
      if (is_prime(n)) exp_q.push_back(n);
    end
    ecount = exp_q.size();
    start_value = W'(s);
    limit       = W'(l);
    start       = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, (s <= l));
  endtask

  task automatic wait_done(int budget);
    int c;
    c = 0;
    while (!done && c < budget) begin
      tick();
      c++;
    end
    check("done_reached", done, 1);
  endtask

  task automatic finish_search(int ecount, int budget);
    wait_done(budget);
    check("prime_count", prime_count, ecount);
    check("scoreboard_empty", exp_q.size(), 0);
    check("busy_at_done", busy, 0);
  endtask

  task automatic run_search(int s, int l, int budget);
    int ec;
    begin_search(s, l, ec);
    finish_search(ec, budget);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_eng_req"}, eng_req, 0);
    check({tag, "_eng_n"}, eng_n, 0);
    check({tag, "_eng_a"}, eng_a, 0);
    check({tag, "_prime_valid"}, prime_valid, 0);
    check({tag, "_prime_data"}, prime_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_count"}, prime_count, 0);
  endtask

  initial begin : stimulus
    int ec;
    int c;
    int s;
    rst = 1'b1; start = 1'b0; abort = 1'b0; start_value = '0; limit = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // full small range with an always-ready consumer
    run_search(1, 30, 5000);

    // no primes; only odd candidates may reach the engine
    run_search(24, 28, 2000);
    check("req_24_28_count", req_n.size(), 2);
    if (req_n.size() == 2) begin
      check("req_first_n", req_n[0], 25);
      check("req_second_n", req_n[1], 27);
    end

    // candidate 5 uses only bases 2 and 3
    run_search(5, 5, 500);
    check("req_5_count", req_n.size(), 2);
    if (req_a.size() == 2) begin
      check("req_5_a0", req_a[0], 2);
      check("req_5_a1", req_a[1], 3);
    end

    // empty range goes straight to done
    begin_search(10, 5, ec);
    check("empty_done", done, 1);
    check("empty_count", prime_count, 0);

    // consumer back-pressure on the first prime
    ready_mode = 2;
    begin_search(1, 30, ec);
    c = 0;
    while (!prime_valid && c < 100) begin
      tick();
      c++;
    end
    check("bp_valid_seen", prime_valid, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_valid", prime_valid, 1);
      check("bp_data", prime_data, 2);
      check("bp_no_req", eng_req, 0);
    end
    ready_mode = 0;
    finish_search(ec, 5000);

    // abort while the engine works on 97
    fixed_lat = 5;
    granted_flag = 1'b0;
    begin_search(97, 97, ec);
    exp_q.delete();
    c = 0;
    while (!granted_flag && c < 100) begin
      tick();
      c++;
    end
    check("abort_grant_seen", granted_flag, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("drain_busy", busy, 1);
    check("drain_no_valid", prime_valid, 0);
    c = 0;
    while (busy && c < 30) begin
      tick();
      c++;
    end
    check("abort_idle_busy", busy, 0);
    check("abort_idle_done", done, 0);
    check("abort_count", prime_count, 0);
    fixed_lat = -1;
    repeat (3) tick();

    // top of the 16-bit range must stop without wrapping
    run_search(65519, 65535, 3000);

    // asynchronous reset in the middle of a search
    begin_search(100, 300, ec);
    repeat (40) tick();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst = 1'b0;
    exp_q.delete();
    repeat (15) tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", prime_valid, 0);
    check("post_rst_req", eng_req, 0);
    check("post_rst_count", prime_count, 0);

    // randomized ranges with random ready and grant
    ready_mode = 1;
    gnt_pct = 50;
    for (int k = 0; k < 3; k++) begin
      s = int'($urandom_range(0, 400));
      run_search(s, s + int'($urandom_range(0, 60)), 10000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
